// File: rtl/tage_update_ctrl.sv
// tage_update_ctrl: buffers resolved-branch updates and replays each one into
// the TAGE tagged tables, first as a provider counter/usefulness update and
// then, on a mispredict, as an allocation pass over the longer-history tables.
module tage_update_ctrl #(
    parameter int NUM_TABLES = 4,
    parameter int ADDR_W     = 6,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          IN_updValid,
    output logic                          OUT_updReady,
    input  logic [NUM_TABLES*ADDR_W-1:0]  IN_updAddr,
    input  logic [NUM_TABLES*TAG_W-1:0]   IN_updTag,
    input  logic                          IN_updProvValid,
    input  logic [$clog2(NUM_TABLES)-1:0] IN_updProvIdx,
    input  logic                          IN_updTaken,
    input  logic                          IN_updMispred,
    output logic [NUM_TABLES-1:0]         OUT_tWriteValid,
    output logic [NUM_TABLES-1:0]         OUT_tWriteUpdate,
    output logic [NUM_TABLES-1:0]         OUT_tWriteNew,
    output logic [NUM_TABLES*ADDR_W-1:0]  OUT_tWriteAddr,
    output logic [NUM_TABLES*TAG_W-1:0]   OUT_tWriteTag,
    output logic                          OUT_tWriteTaken,
    output logic                          OUT_tWriteUseful,
    input  logic [NUM_TABLES-1:0]         IN_tWriteAlloc,
    output logic                          OUT_tAnyAlloc,
    output logic                          OUT_busy,
    output logic [7:0]                    OUT_allocFailCnt
);

    localparam int PIW   = $clog2(NUM_TABLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AW    = NUM_TABLES * ADDR_W;
    localparam int TW    = NUM_TABLES * TAG_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PIW-1:0]   LAST_TBL = PIW'(NUM_TABLES - 1);

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [TW-1:0]  tag;
        logic           prov_valid;
        logic [PIW-1:0] prov_idx;
        logic           taken;
        logic           mispred;
    } upd_entry_t;

    localparam int ENTRY_W = $bits(upd_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_ALLOC  = 2'd2
    } state_e;

    upd_entry_t       mem_q [FIFO_DEPTH];
    upd_entry_t       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    upd_entry_t       work_q, work_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;

    upd_entry_t            in_entry_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [NUM_TABLES-1:0] wr_valid_s;
    logic [NUM_TABLES-1:0] wr_update_s;
    logic [NUM_TABLES-1:0] wr_new_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == CNT_W'(0));
    // Ready is held low while reset is applied and whenever the queue is full.
    assign OUT_updReady = rst && !full_s;
    assign push_s  = IN_updValid && OUT_updReady;
    assign pop_s   = (state_q == ST_IDLE) && !empty_s;

    // Pack the incoming request into a queue entry.
    always_comb begin
        in_entry_s.addr       = IN_updAddr;
        in_entry_s.tag        = IN_updTag;
        in_entry_s.prov_valid = IN_updProvValid;
        in_entry_s.prov_idx   = IN_updProvIdx;
        in_entry_s.taken      = IN_updTaken;
        in_entry_s.mispred    = IN_updMispred;
    end

    // Queue storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = in_entry_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer: next state, working entry, fail counter and table strobes.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        fail_cnt_d  = fail_cnt_q;
        wr_valid_s  = {NUM_TABLES{1'b0}};
        wr_update_s = {NUM_TABLES{1'b0}};
        wr_new_s    = {NUM_TABLES{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    work_d = mem_q[rd_ptr_q];
                    if (mem_q[rd_ptr_q].prov_valid) begin
                        state_d = ST_UPDATE;
                    end else if (mem_q[rd_ptr_q].mispred) begin
                        state_d = ST_ALLOC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                wr_valid_s[work_q.prov_idx]  = 1'b1;
                wr_update_s[work_q.prov_idx] = 1'b1;
                if (work_q.mispred && (work_q.prov_idx < LAST_TBL)) begin
                    state_d = ST_ALLOC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALLOC: begin
                // Only tables with longer history than the provider may allocate.
                for (int k = 0; k < NUM_TABLES; k++) begin
                    if (!work_q.prov_valid || (k > int'(work_q.prov_idx))) begin
                        wr_valid_s[k] = 1'b1;
                        wr_new_s[k]   = 1'b1;
                    end else begin
                        wr_valid_s[k] = 1'b0;
                        wr_new_s[k]   = 1'b0;
                    end
                end
                if (!(|IN_tWriteAlloc) && (fail_cnt_q != 8'hFF)) begin
                    fail_cnt_d = fail_cnt_q + 8'd1;
                end else begin
                    fail_cnt_d = fail_cnt_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, queue and working registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= upd_entry_t'({ENTRY_W{1'b0}});
            end
            wr_ptr_q   <= PTR_W'(0);
            rd_ptr_q   <= PTR_W'(0);
            count_q    <= CNT_W'(0);
            state_q    <= ST_IDLE;
            work_q     <= upd_entry_t'({ENTRY_W{1'b0}});
            fail_cnt_q <= 8'd0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            work_q     <= work_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign OUT_tWriteValid  = wr_valid_s;
    assign OUT_tWriteUpdate = wr_update_s;
    assign OUT_tWriteNew    = wr_new_s;
    assign OUT_tWriteAddr   = work_q.addr;
    assign OUT_tWriteTag    = work_q.tag;
    assign OUT_tWriteTaken  = work_q.taken;
    assign OUT_tWriteUseful = !work_q.mispred;
    // The allocation OR is the one combinational path from the tables back out.
    assign OUT_tAnyAlloc    = (state_q == ST_ALLOC) && (|IN_tWriteAlloc);
    assign OUT_busy         = !empty_s || (state_q != ST_IDLE);
    assign OUT_allocFailCnt = fail_cnt_q;

endmodule

// File: doc/tage_update_ctrl.md
# tage_update_ctrl

Sequences resolved-branch updates into the TAGE tagged tables. Resolution requests are buffered in a small FIFO and replayed one at a time: first a counter/usefulness update on the providing table, then, on a misprediction, an allocation pass over all longer-history tables. The block sits between branch resolution in the back end and the `TageTable` instances, and owns every table write port and the shared any-allocation signal.

## Interface
- `NUM_TABLES`, 4: number of tagged tables; index 0 is the shortest history.
- `ADDR_W`, 6: per-table index width.
- `TAG_W`, 8: per-table tag width.
- `FIFO_DEPTH`, 4: update queue entries; power of two, at least 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `IN_updValid` in 1: update request valid.
- `OUT_updReady` in the out direction, width 1: FIFO can accept a request.
- `IN_updAddr` in NUM_TABLES*ADDR_W: per-table index; table k uses bits [k*ADDR_W +: ADDR_W].
- `IN_updTag` in NUM_TABLES*TAG_W: per-table tag, packed the same way.
- `IN_updProvValid` in 1: some tagged table provided the prediction.
- `IN_updProvIdx` in $clog2(NUM_TABLES): provider table index.
- `IN_updTaken` in 1: actual branch outcome.
- `IN_updMispred` in 1: the final prediction was wrong.
- `OUT_tWriteValid` out NUM_TABLES: per-table write valid.
- `OUT_tWriteUpdate` out NUM_TABLES: per-table update-mode select.
- `OUT_tWriteNew` out NUM_TABLES: per-table allocate request.
- `OUT_tWriteAddr` out NUM_TABLES*ADDR_W: per-table index from the working entry.
- `OUT_tWriteTag` out NUM_TABLES*TAG_W: per-table tag from the working entry.
- `OUT_tWriteTaken` out 1: outcome broadcast to all tables.
- `OUT_tWriteUseful` out 1: usefulness direction, equal to !mispred.
- `IN_tWriteAlloc` in NUM_TABLES: per-table "allocated this cycle" flag.
- `OUT_tAnyAlloc` out 1: OR of `IN_tWriteAlloc`, broadcast to all tables.
- `OUT_busy` out 1: FIFO non-empty or FSM not in IDLE.
- `OUT_allocFailCnt` out 8: saturating count of allocation passes where no table allocated.

## Operation
- FIFO stores {addr, tag, provValid, provIdx, taken, mispred}.
- Push on `IN_updValid && OUT_updReady`. `OUT_updReady = !full`. There is no bypass, so a push while full is not accepted.
- FSM states are IDLE, UPDATE and ALLOC.
- **IDLE**
  - If the FIFO is non-empty, pop the head into the working registers.
  - Next state is UPDATE if provValid.
  - Otherwise, next state is ALLOC if mispred.
  - Otherwise, stay in IDLE. This discards the entry.
- **UPDATE**
  - Only the provider p is written: `OUT_tWriteValid[p]=1`, `OUT_tWriteUpdate[p]=1`.
  - Next state is ALLOC if mispred and p < NUM_TABLES-1. Otherwise, next state is IDLE.
- **ALLOC**
  - The eligible set is tables k > p, or all tables if !provValid.
  - For each eligible table: `OUT_tWriteValid[k]=1`, `OUT_tWriteNew[k]=1`, `OUT_tWriteUpdate[k]=0`.
  - `OUT_tAnyAlloc` is the combinational OR of `IN_tWriteAlloc` in the same cycle. Tables that did not allocate then skip their usefulness decrement.
  - If the OR is 0, increment `OUT_allocFailCnt`, saturating at 255.
  - Next state is IDLE.
- In IDLE, and for non-selected tables, all per-table valid/new/update bits are 0.
- `OUT_tWriteAddr`, `OUT_tWriteTag`, `OUT_tWriteTaken` and `OUT_tWriteUseful` always reflect the working registers.
- `OUT_tAnyAlloc` is 0 outside ALLOC.
- All table-facing outputs are Moore, decoded from state and working registers. The only exception is `OUT_tAnyAlloc`.

## Timing
- Reset while `rst` is low:
  - FIFO is empty, pointers and count are 0, state is IDLE.
  - Working registers and `OUT_allocFailCnt` are 0.
  - All table write strobes are 0, `OUT_updReady=0`, `OUT_busy=0`.
- First push is possible in the first cycle after `rst` rises.
- Push-to-pop: an entry pushed in cycle t is popped in t+1 at the earliest, with UPDATE in t+2 and ALLOC in t+3.
- Cost per entry:
  - Correct hit: 2 cycles.
  - Mispredict hit: 3 cycles.
  - Miss with mispredict: 2 cycles.
  - Miss and correct: 1 cycle.
- A simultaneous push and pop in IDLE with the FIFO full is allowed only if ready was already high. Count is unchanged when both occur.
- Asynchronous reset mid-UPDATE or mid-ALLOC aborts the current operation. Strobes drop immediately and queued entries are lost.
- Pointers wrap modulo `FIFO_DEPTH`.

## Test plan
- **Correct hit.** Push provValid=1, provIdx=2, mispred=0, taken=1.
  - UPDATE cycle: `OUT_tWriteValid=4'b0100`, `OUT_tWriteUpdate=4'b0100`, `OUT_tWriteUseful=1`.
  - No ALLOC follows. FSM returns to IDLE and `OUT_busy` falls.
- **Mispredict with allocation.** Push provIdx=1, mispred=1, and tie `IN_tWriteAlloc=4'b0100`.
  - UPDATE strobes table 1 with `OUT_tWriteUseful=0`.
  - ALLOC: `OUT_tWriteNew=4'b1100`, `OUT_tAnyAlloc=1`.
  - `OUT_allocFailCnt` stays 0.
- **Miss with no allocation.** Push provValid=0, mispred=1, and tie `IN_tWriteAlloc=0`.
  - ALLOC directly after pop with `OUT_tWriteNew=4'b1111` and `OUT_tAnyAlloc=0`.
  - `OUT_allocFailCnt` goes 0→1. After 300 repeats it reads 255.
- **Provider is the longest table.** Push provIdx=3, mispred=1.
  - UPDATE only, no ALLOC cycle.
- **Backpressure.** Push 6 requests back-to-back while the FSM is held busy.
  - `OUT_updReady` drops after the 4th accepted push.
  - All 4 entries drain in FIFO order, checked by the per-table addr/tag values.
  - Pointers wrap correctly on refill.
- **Reset mid-ALLOC.** Assert `rst` low during an ALLOC cycle.
  - Strobes go to 0 asynchronously.
  - After release: `OUT_busy=0`, `OUT_updReady=1`, counter 0.
